// File: rtl/dms_pkg.sv
// Shared definitions for the DMS transmit encoder: FSM state encoding,
// key-width limits, default symbol timing and the key-width helper.
package dms_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CFG_N  = 3'd1,
    CFG_D  = 3'd2,
    CFG_C  = 3'd3,
    SYM_HI = 3'd4,
    SYM_LO = 3'd5,
    CLOSE  = 3'd6
  } dms_state_e;

  localparam int MAX_W         = 32;
  localparam int MAX_LOG2W_DEF = 5;
  localparam int SYM_LEN_DEF   = 16;
  localparam int SHORT_LEN_DEF = 4;

  // Key width W = 2^n; only called with n <= 5, so the result fits in 6 bits.
  function automatic logic [5:0] key_width(input logic [3:0] n);
    return 6'd1 << n;
  endfunction

endpackage

// File: rtl/dms_sym_timer.sv
// Loadable 6-bit down-counter timing one HI or LO segment of a data symbol.
// Loading L-1 gives a segment of L clocks; done marks the segment's last clock.
module dms_sym_timer (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [5:0] load_val,
  output logic       done,
  output logic       done_next
);

  logic [5:0] cnt;

  // Count down to the terminal count and park there until reloaded.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= 6'd0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != 6'd0) begin
      cnt <= cnt - 6'd1;
    end
  end

  assign done = (cnt == 6'd0);

  // Lets the owner register "last clock of segment" outputs one cycle early.
  assign done_next = load ? (load_val == 6'd0) : (cnt <= 6'd1);

endmodule

// File: rtl/dms_encoder.sv
// Transmit-side line encoder feeding the SAM decoder: serialises the key
// configuration (n, d, capsN) with mode=1, then sends data frames as
// pulse-width-coded symbols with mode=0. All outputs come straight from flops.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | line parked high; accepts a config request or a frame's first bit
// CFG_N  | shifting n[3]..n[0]
// CFG_D  | shifting d[W-1]..d[0]
// CFG_C  | shifting caps[W-1]..caps[0]
// SYM_HI | high segment of a symbol (also used by the sync symbol)
// SYM_LO | low segment of a symbol, or the one-cycle lead-in before sync
// CLOSE  | single high cycle giving the decoder its terminating rising edge
module dms_encoder
  import dms_pkg::*;
#(
  parameter int MAX_LOG2W = MAX_LOG2W_DEF,
  parameter int SYM_LEN   = SYM_LEN_DEF,
  parameter int SHORT_LEN = SHORT_LEN_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cfg_start,
  input  logic [3:0]  cfg_n,
  input  logic [31:0] cfg_d,
  input  logic [31:0] cfg_caps,
  output logic        cfg_err,
  output logic        configured,
  input  logic        tx_valid,
  input  logic        tx_bit,
  input  logic        tx_last,
  output logic        tx_ready,
  output logic        underrun,
  output logic        busy,
  output logic        mode,
  output logic        str
);

  localparam logic [5:0] SHORT_LD = 6'(SHORT_LEN - 1);
  localparam logic [5:0] LONG_LD  = 6'(SYM_LEN - SHORT_LEN - 1);

  dms_state_e  state, state_nx;
  logic [5:0]  bit_cnt, bit_cnt_nx;
  logic [3:0]  n_r, n_nx;
  logic [31:0] d_r, d_nx;
  logic [31:0] caps_r, caps_nx;
  logic        configured_nx;

  // One-entry buffer: the frame's first bit waits here during sync, and a bit
  // accepted while another is still queued waits here for its symbol.
  logic        hold_vld, hold_vld_nx;
  logic        hold_bit, hold_bit_nx;
  logic        hold_last, hold_last_nx;

  // Symbol currently on the line; lead marks the lead-in low cycle.
  logic        cur_bit, cur_bit_nx;
  logic        cur_last, cur_last_nx;
  logic        lead, lead_nx;

  logic        str_nx, mode_nx, busy_nx, tx_ready_nx, cfg_err_nx, underrun_nx;

  logic        tmr_load;
  logic [5:0]  tmr_val;
  logic        tmr_done, tmr_done_nx;
  logic        hs;

  assign hs = tx_valid & tx_ready;

  dms_sym_timer u_timer (
    .clk       (clk),
    .reset     (reset),
    .load      (tmr_load),
    .load_val  (tmr_val),
    .done      (tmr_done),
    .done_next (tmr_done_nx)
  );

  // Length of the high segment for a symbol carrying bit b, as a timer load.
  function automatic logic [5:0] hi_ld(input logic b);
    return b ? LONG_LD : SHORT_LD;
  endfunction

  // State register plus every output and working register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      bit_cnt    <= 6'd0;
      n_r        <= 4'd0;
      d_r        <= 32'd0;
      caps_r     <= 32'd0;
      configured <= 1'b0;
      hold_vld   <= 1'b0;
      hold_bit   <= 1'b0;
      hold_last  <= 1'b0;
      cur_bit    <= 1'b0;
      cur_last   <= 1'b0;
      lead       <= 1'b0;
      str        <= 1'b1;
      mode       <= 1'b0;
      busy       <= 1'b0;
      tx_ready   <= 1'b0;
      cfg_err    <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      state      <= state_nx;
      bit_cnt    <= bit_cnt_nx;
      n_r        <= n_nx;
      d_r        <= d_nx;
      caps_r     <= caps_nx;
      configured <= configured_nx;
      hold_vld   <= hold_vld_nx;
      hold_bit   <= hold_bit_nx;
      hold_last  <= hold_last_nx;
      cur_bit    <= cur_bit_nx;
      cur_last   <= cur_last_nx;
      lead       <= lead_nx;
      str        <= str_nx;
      mode       <= mode_nx;
      busy       <= busy_nx;
      tx_ready   <= tx_ready_nx;
      cfg_err    <= cfg_err_nx;
      underrun   <= underrun_nx;
    end
  end

  // Next-state logic: config shifting, symbol segment sequencing, frame flow.
  always_comb begin
    state_nx      = state;
    bit_cnt_nx    = bit_cnt;
    n_nx          = n_r;
    d_nx          = d_r;
    caps_nx       = caps_r;
    configured_nx = configured;
    hold_vld_nx   = hold_vld;
    hold_bit_nx   = hold_bit;
    hold_last_nx  = hold_last;
    cur_bit_nx    = cur_bit;
    cur_last_nx   = cur_last;
    lead_nx       = lead;
    tmr_load      = 1'b0;
    tmr_val       = 6'd0;
    cfg_err_nx    = 1'b0;
    underrun_nx   = 1'b0;

    case (state)
      IDLE: begin
        if (cfg_start) begin
          if (cfg_n > 4'(MAX_LOG2W)) begin
            cfg_err_nx = 1'b1;
          end else begin
            n_nx          = cfg_n;
            d_nx          = cfg_d;
            caps_nx       = cfg_caps;
            configured_nx = 1'b0;
            bit_cnt_nx    = 6'd3;
            state_nx      = CFG_N;
          end
        end else if (hs) begin
          // Queue the bit and open the frame with lead-in low, then sync (a 0).
          hold_vld_nx  = 1'b1;
          hold_bit_nx  = tx_bit;
          hold_last_nx = tx_last;
          cur_bit_nx   = 1'b0;
          cur_last_nx  = 1'b0;
          lead_nx      = 1'b1;
          tmr_load     = 1'b1;
          tmr_val      = 6'd0;
          state_nx     = SYM_LO;
        end
      end

      CFG_N: begin
        if (bit_cnt != 6'd0) begin
          bit_cnt_nx = bit_cnt - 6'd1;
        end else begin
          bit_cnt_nx = key_width(n_r) - 6'd1;
          state_nx   = CFG_D;
        end
      end

      CFG_D: begin
        if (bit_cnt != 6'd0) begin
          bit_cnt_nx = bit_cnt - 6'd1;
        end else begin
          bit_cnt_nx = key_width(n_r) - 6'd1;
          state_nx   = CFG_C;
        end
      end

      CFG_C: begin
        if (bit_cnt != 6'd0) begin
          bit_cnt_nx = bit_cnt - 6'd1;
        end else begin
          configured_nx = 1'b1;
          state_nx      = IDLE;
        end
      end

      SYM_HI: begin
        if (tmr_done) begin
          tmr_load = 1'b1;
          tmr_val  = cur_bit ? SHORT_LD : LONG_LD;
          state_nx = SYM_LO;
        end
      end

      SYM_LO: begin
        if (tmr_done) begin
          if (lead) begin
            lead_nx  = 1'b0;
            tmr_load = 1'b1;
            tmr_val  = hi_ld(cur_bit);
            state_nx = SYM_HI;
          end else if (cur_last) begin
            state_nx = CLOSE;
          end else if (hold_vld) begin
            cur_bit_nx  = hold_bit;
            cur_last_nx = hold_last;
            tmr_load    = 1'b1;
            tmr_val     = hi_ld(hold_bit);
            state_nx    = SYM_HI;
            if (hs) begin
              hold_bit_nx  = tx_bit;
              hold_last_nx = tx_last;
            end else begin
              hold_vld_nx = 1'b0;
            end
          end else if (hs) begin
            cur_bit_nx  = tx_bit;
            cur_last_nx = tx_last;
            tmr_load    = 1'b1;
            tmr_val     = hi_ld(tx_bit);
            state_nx    = SYM_HI;
          end else begin
            underrun_nx = 1'b1;
            state_nx    = CLOSE;
          end
        end
      end

      CLOSE: begin
        // A bit accepted while the frame's last bit was being launched has no
        // frame to belong to and is dropped here.
        hold_vld_nx = 1'b0;
        cur_last_nx = 1'b0;
        state_nx    = IDLE;
      end

      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Output values for the next cycle, derived from where the FSM is heading.
  always_comb begin
    case (state_nx)
      CFG_N:   str_nx = n_nx[bit_cnt_nx[1:0]];
      CFG_D:   str_nx = d_nx[bit_cnt_nx[4:0]];
      CFG_C:   str_nx = caps_nx[bit_cnt_nx[4:0]];
      SYM_LO:  str_nx = 1'b0;
      default: str_nx = 1'b1;
    endcase
    mode_nx = (state_nx == CFG_N) || (state_nx == CFG_D) || (state_nx == CFG_C);
    busy_nx = (state_nx != IDLE);
    if (state_nx == IDLE) begin
      tx_ready_nx = configured_nx;
    end else begin
      tx_ready_nx = (state_nx == SYM_LO) && !lead_nx && !cur_last_nx && tmr_done_nx;
    end
  end

endmodule

// File: tb/tb_dms_encoder.sv
// Bench for dms_encoder: expected line waveforms are built from the symbol
// and configuration rules, then compared cycle by cycle on the falling edge.
module tb_dms_encoder;

  localparam int SL = 16;
  localparam int SH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cfg_start, tx_valid, tx_bit, tx_last;
  logic [3:0]  cfg_n;
  logic [31:0] cfg_d, cfg_caps;
  logic        cfg_err, configured, tx_ready, underrun, busy, mode, str;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic str;
    logic mode;
    logic busy;
    logic rdy;
    logic cfgd;
    logic udr;
  } exp_t;

  exp_t        exq[$];
  logic        bq[$];
  logic        frame_last;
  logic [63:0] str_hist;

  dms_encoder #(.MAX_LOG2W(5), .SYM_LEN(SL), .SHORT_LEN(SH)) dut (
    .clk        (clk),
    .reset      (reset),
    .cfg_start  (cfg_start),
    .cfg_n      (cfg_n),
    .cfg_d      (cfg_d),
    .cfg_caps   (cfg_caps),
    .cfg_err    (cfg_err),
    .configured (configured),
    .tx_valid   (tx_valid),
    .tx_bit     (tx_bit),
    .tx_last    (tx_last),
    .tx_ready   (tx_ready),
    .underrun   (underrun),
    .busy       (busy),
    .mode       (mode),
    .str        (str)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input string fld, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, fld, obs, exp_v);
    end
  endtask

  task automatic push_e(input logic s, input logic m, input logic b, input logic r, input logic c, input logic u);
    exp_t e;
    e.str = s; e.mode = m; e.busy = b; e.rdy = r; e.cfgd = c; e.udr = u;
    exq.push_back(e);
  endtask

  // Config: n MSB first, then W bits of d, then W bits of caps, then idle.
  task automatic model_cfg(input int n, input logic [31:0] d, input logic [31:0] c);
    logic [3:0] nn;
    int w;
    nn = n[3:0];
    w  = 1 << n;
    for (int i = 3; i >= 0; i--)   push_e(nn[i], 1, 1, 0, 0, 0);
    for (int i = w - 1; i >= 0; i--) push_e(d[i], 1, 1, 0, 0, 0);
    for (int i = w - 1; i >= 0; i--) push_e(c[i], 1, 1, 0, 0, 0);
    push_e(1, 0, 0, 1, 1, 0);
  endtask

  // One symbol: majority high for a 1, majority low for a 0.
  task automatic model_sym(input logic b, input logic rdy_end);
    int hi;
    hi = b ? SL - SH : SH;
    for (int i = 0; i < hi; i++)      push_e(1, 0, 1, 0, 1, 0);
    for (int i = 0; i < SL - hi; i++) push_e(0, 0, 1, rdy_end && (i == SL - hi - 1), 1, 0);
  endtask

  // Frame: lead-in low, sync 0, each queued bit, close high, then idle.
  task automatic model_frame(input logic ends_last);
    push_e(0, 0, 1, 0, 1, 0);
    model_sym(1'b0, 1'b1);
    for (int i = 0; i < bq.size(); i++)
      model_sym(bq[i], !(ends_last && (i == bq.size() - 1)));
    push_e(1, 0, 1, 0, 1, !ends_last);
    push_e(1, 0, 0, 1, 1, 0);
  endtask

  task automatic play(input string tag, input int first_nxt);
    exp_t e;
    int nxt;
    nxt = first_nxt;
    while (exq.size() > 0) begin
      e = exq.pop_front();
      @(negedge clk);
      cfg_start = 1'b0;
      if (mode) str_hist = {str_hist[62:0], str};
      chk(tag, "str",        {31'd0, str},        {31'd0, e.str});
      chk(tag, "mode",       {31'd0, mode},       {31'd0, e.mode});
      chk(tag, "busy",       {31'd0, busy},       {31'd0, e.busy});
      chk(tag, "tx_ready",   {31'd0, tx_ready},   {31'd0, e.rdy});
      chk(tag, "configured", {31'd0, configured}, {31'd0, e.cfgd});
      chk(tag, "underrun",   {31'd0, underrun},   {31'd0, e.udr});
      chk(tag, "cfg_err",    {31'd0, cfg_err},    32'd0);
      if (tx_ready && (nxt < bq.size())) begin
        tx_valid = 1'b1;
        tx_bit   = bq[nxt];
        tx_last  = frame_last && (nxt == bq.size() - 1);
        nxt++;
      end else begin
        tx_valid = 1'b0;
        tx_last  = 1'b0;
      end
    end
  endtask

  task automatic do_cfg(input string tag, input int n, input logic [31:0] d, input logic [31:0] c, input logic with_tx);
    bq.delete();
    model_cfg(n, d, c);
    str_hist  = 64'd0;
    cfg_start = 1'b1;
    cfg_n     = 4'(n);
    cfg_d     = d;
    cfg_caps  = c;
    tx_valid  = with_tx;
    tx_bit    = 1'b1;
    play(tag, 0);
  endtask

  task automatic do_frame(input string tag, input logic ends_last);
    frame_last = ends_last;
    model_frame(ends_last);
    chk(tag, "idle_ready", {31'd0, tx_ready}, 32'd1);
    tx_valid = 1'b1;
    tx_bit   = bq[0];
    tx_last  = ends_last && (bq.size() == 1);
    play(tag, 1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk(tag, "str",        {31'd0, str},        32'd1);
    chk(tag, "mode",       {31'd0, mode},       32'd0);
    chk(tag, "configured", {31'd0, configured}, 32'd0);
    chk(tag, "busy",       {31'd0, busy},       32'd0);
    chk(tag, "tx_ready",   {31'd0, tx_ready},   32'd0);
    chk(tag, "cfg_err",    {31'd0, cfg_err},    32'd0);
    chk(tag, "underrun",   {31'd0, underrun},   32'd0);
  endtask

  initial begin
    int n, k;
    cfg_start = 0; cfg_n = 0; cfg_d = 0; cfg_caps = 0;
    tx_valid = 0; tx_bit = 0; tx_last = 0; frame_last = 0; str_hist = 0;
    #1 reset = 1'b0;
    #2 chk_reset_vals("rst");
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk_reset_vals("rst_rel");

    // Data offered before any configuration is not accepted.
    tx_valid = 1'b1; tx_bit = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    chk("pre_cfg", "busy",     {31'd0, busy},     32'd0);
    chk("pre_cfg", "tx_ready", {31'd0, tx_ready}, 32'd0);
    chk("pre_cfg", "str",      {31'd0, str},      32'd1);

    do_cfg("cfg_dir", 2, 32'h0000_000a, 32'h0000_0001, 1'b0);
    chk("cfg_dir", "bits", {20'd0, str_hist[11:0]}, {20'd0, 12'b0010_1010_0001});

    // Out-of-range n: one error pulse, line untouched, configuration kept.
    cfg_start = 1'b1; cfg_n = 4'd6;
    @(negedge clk);
    cfg_start = 1'b0;
    chk("cfg_bad", "cfg_err",    {31'd0, cfg_err},    32'd1);
    chk("cfg_bad", "mode",       {31'd0, mode},       32'd0);
    chk("cfg_bad", "str",        {31'd0, str},        32'd1);
    chk("cfg_bad", "configured", {31'd0, configured}, 32'd1);
    chk("cfg_bad", "busy",       {31'd0, busy},       32'd0);
    @(negedge clk);
    chk("cfg_bad2", "cfg_err", {31'd0, cfg_err}, 32'd0);
    chk("cfg_bad2", "busy",    {31'd0, busy},    32'd0);

    bq.delete(); bq.push_back(1'b1); bq.push_back(1'b0);
    do_frame("frm_dir", 1'b1);

    bq.delete(); bq.push_back(1'b1);
    do_frame("frm_udr", 1'b0);

    for (int it = 0; it < 8; it++) begin
      n = int'($urandom_range(0, 5));
      do_cfg("cfg_rnd", n, $urandom, $urandom, 1'($urandom_range(0, 1)));
      k = int'($urandom_range(1, 5));
      bq.delete();
      for (int j = 0; j < k; j++) bq.push_back(1'($urandom_range(0, 1)));
      do_frame("frm_rnd", 1'($urandom_range(0, 1)));
    end

    // Asynchronous reset in the middle of the d field.
    cfg_start = 1'b1; cfg_n = 4'd5; cfg_d = $urandom; cfg_caps = $urandom;
    @(negedge clk);
    cfg_start = 1'b0;
    repeat (10) @(negedge clk);
    chk("rst_mid_pre", "mode", {31'd0, mode}, 32'd1);
    #2 reset = 1'b0;
    #1 chk_reset_vals("rst_mid");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk_reset_vals("rst_mid_rel");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
